// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin req/ack arbiter sharing one single-port memory
// between the CPU datapath (port 0) and the loader/debug port (port 1).
// Each grant runs one memory operation through IDLE -> ISSUE -> RESP -> ACK.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_val,
  output logic              mem_get,
  output logic              mem_set,
  input  logic [DATA_W-1:0] mem_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP,
    S_ACK
  } state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;   // port granted most recently
  logic                gnt_q, gnt_d;     // current grantee
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  // State and transaction registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state: arbitrate and latch the request in IDLE, capture read data in RESP.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the port not served last wins; otherwise the lone requester.
          gnt_d   = (req0 && req1) ? ~last_q : req1;
          we_d    = gnt_d ? we1    : we0;
          addr_d  = gnt_d ? addr1  : addr0;
          wdata_d = gnt_d ? wdata1 : wdata0;
          last_d  = gnt_d;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_RESP;
      S_RESP: begin
        if (!we_q) rdata_d = mem_out;
        state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded purely from registered state; no path from req inputs.
  always_comb begin
    mem_addr = addr_q;
    mem_val  = wdata_q;
    mem_get  = (state_q == S_ISSUE) && !we_q;
    mem_set  = (state_q == S_ISSUE) &&  we_q;
    ack0     = (state_q == S_ACK) && !gnt_q;
    ack1     = (state_q == S_ACK) &&  gnt_q;
    busy     = (state_q != S_IDLE);
    rdata    = rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural single-port memory
// that registers its read output.
module tb_mem_arbiter;

  logic       clk, reset;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       ack0, ack1, busy, mem_get, mem_set;
  logic [7:0] rdata, mem_addr, mem_val, mem_out;

  int n_checks;
  int n_fail;

  logic [7:0] mem [256];

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_val(mem_val), .mem_get(mem_get), .mem_set(mem_set),
    .mem_out(mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem_out = 8'h00;
  end

  always @(posedge clk) begin
    if (mem_set) mem[mem_addr] <= mem_val;
    if (mem_get) mem_out <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    #3;
    n_checks++; if ({ack0, ack1, busy, mem_get, mem_set} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {ack0, ack1, busy, mem_get, mem_set}); end
    n_checks++; if ({mem_addr, mem_val, rdata} !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h want 000000", {mem_addr, mem_val, rdata}); end
    tick();
    reset = 1'b0;
    tick();
    // write to 0x10, reset lands in the middle of its ISSUE cycle
    req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 8'h5A;
    tick();
    n_checks++; if (mem_set !== 1'b1) begin n_fail++; $display("FAIL reset_pre_issue: mem_set=%b want 1", mem_set); end
    #3;
    reset = 1'b1;
    #1;
    n_checks++; if (mem_set !== 1'b0) begin n_fail++; $display("FAIL reset_async_set: mem_set=%b want 0", mem_set); end
    n_checks++; if ({ack0, ack1, busy, mem_get} !== 4'b0) begin n_fail++; $display("FAIL reset_async_ctrl: got %b want 0000", {ack0, ack1, busy, mem_get}); end
    n_checks++; if ({mem_addr, mem_val} !== 16'h0) begin n_fail++; $display("FAIL reset_async_data: got %h want 0000", {mem_addr, mem_val}); end
    req0 = 0; we0 = 0;
    tick();
    reset = 1'b0;
    tick();
    n_checks++; if ({ack0, busy} !== 2'b0) begin n_fail++; $display("FAIL reset_no_ack: got %b want 00", {ack0, busy}); end
    // read back 0x10: the lost write must not appear
    req0 = 1; we0 = 0; addr0 = 8'h10;
    tick(); tick(); tick();
    n_checks++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL reset_readback_ack: ack0=%b want 1", ack0); end
    n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_lost_write: rdata=%h want 00", rdata); end
    req0 = 0;
    tick();
  endtask

  task automatic test_single_port0();
    req0 = 1; we0 = 1; addr0 = 8'h3C; wdata0 = 8'hA5;
    n_checks++; if ({mem_set, mem_get, busy} !== 3'b0) begin n_fail++; $display("FAIL wr_T_no_comb: got %b want 000", {mem_set, mem_get, busy}); end
    tick();
    n_checks++; if ({mem_set, mem_get, busy, ack0} !== 4'b1010) begin n_fail++; $display("FAIL wr_issue_ctrl: got %b want 1010", {mem_set, mem_get, busy, ack0}); end
    n_checks++; if ({mem_addr, mem_val} !== 16'h3CA5) begin n_fail++; $display("FAIL wr_issue_data: got %h want 3ca5", {mem_addr, mem_val}); end
    tick();
    n_checks++; if ({mem_set, mem_get, ack0, busy} !== 4'b0001) begin n_fail++; $display("FAIL wr_resp: got %b want 0001", {mem_set, mem_get, ack0, busy}); end
    n_checks++; if ({mem_addr, mem_val} !== 16'h3CA5) begin n_fail++; $display("FAIL wr_resp_hold: got %h want 3ca5", {mem_addr, mem_val}); end
    tick();
    n_checks++; if ({ack0, ack1} !== 2'b10) begin n_fail++; $display("FAIL wr_ack: got %b want 10", {ack0, ack1}); end
    n_checks++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL wr_rdata_hold: rdata=%h want 00", rdata); end
    req0 = 0;
    tick();
    n_checks++; if ({ack0, busy} !== 2'b00) begin n_fail++; $display("FAIL wr_idle: got %b want 00", {ack0, busy}); end
    req0 = 1; we0 = 0; addr0 = 8'h3C; wdata0 = 8'h00;
    tick();
    n_checks++; if ({mem_get, mem_set, mem_addr} !== 10'b10_0011_1100) begin n_fail++; $display("FAIL rd_issue: got %b want 1000111100", {mem_get, mem_set, mem_addr}); end
    tick(); tick();
    n_checks++; if ({ack0, ack1} !== 2'b10) begin n_fail++; $display("FAIL rd_ack: got %b want 10", {ack0, ack1}); end
    n_checks++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL rd_data: rdata=%h want a5", rdata); end
    req0 = 0;
    tick();
  endtask

  task automatic test_tie();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1; we0 = 0; addr0 = 8'h01;
    req1 = 1; we1 = 1; addr1 = 8'h02; wdata1 = 8'h77;
    tick();
    n_checks++; if ({mem_get, mem_set, mem_addr} !== 10'b10_0000_0001) begin n_fail++; $display("FAIL tie_p0_issue: got %b want 1000000001", {mem_get, mem_set, mem_addr}); end
    tick(); tick();
    n_checks++; if ({ack0, ack1} !== 2'b10) begin n_fail++; $display("FAIL tie_p0_ack: got %b want 10", {ack0, ack1}); end
    req0 = 0;
    tick();
    n_checks++; if ({busy, ack0, ack1} !== 3'b000) begin n_fail++; $display("FAIL tie_t4_idle: got %b want 000", {busy, ack0, ack1}); end
    tick();
    n_checks++; if ({mem_set, mem_get} !== 2'b10 || {mem_addr, mem_val} !== 16'h0277) begin n_fail++; $display("FAIL tie_p1_issue: ctl %b data %h want 10 0277", {mem_set, mem_get}, {mem_addr, mem_val}); end
    tick(); tick();
    n_checks++; if ({ack0, ack1} !== 2'b01) begin n_fail++; $display("FAIL tie_p1_ack: got %b want 01", {ack0, ack1}); end
    req1 = 0; we1 = 0;
    tick();
  endtask

  task automatic test_contention();
    int c0, c1;
    logic exp_ack;
    logic prev;
    c0 = 0; c1 = 0; prev = 1'b1;
    req0 = 1; we0 = 0; addr0 = 8'h3C;
    req1 = 1; we1 = 0; addr1 = 8'h02;
    for (int i = 1; i <= 32; i++) begin
      tick();
      exp_ack = ((i % 4) == 3);
      n_checks++; if ({ack0, ack1} === 2'b11 || (ack0 | ack1) !== exp_ack) begin n_fail++; $display("FAIL cont_cadence cycle %0d: acks %b want any=%b", i, {ack0, ack1}, exp_ack); end
      if (ack0 || ack1) begin
        n_checks++; if (ack1 !== ~prev) begin n_fail++; $display("FAIL cont_alternate cycle %0d: ack1=%b want %b", i, ack1, ~prev); end
        n_checks++; if (rdata !== (ack1 ? 8'h77 : 8'hA5)) begin n_fail++; $display("FAIL cont_rdata cycle %0d: rdata=%h want %h", i, rdata, ack1 ? 8'h77 : 8'hA5); end
        prev = ack1;
        if (ack0) c0++;
        if (ack1) c1++;
      end
    end
    req0 = 0; req1 = 0;
    n_checks++; if (c0 !== 4 || c1 !== 4) begin n_fail++; $display("FAIL cont_counts: port0=%0d port1=%0d want 4 4", c0, c1); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_drain: busy=%b want 0", busy); end
  endtask

  task automatic test_addr_change();
    int pulses;
    pulses = 0;
    req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 8'h3E;
    tick();
    n_checks++; if ({mem_set, mem_addr} !== 9'h120) begin n_fail++; $display("FAIL chg_issue: got %h want 120", {mem_set, mem_addr}); end
    tick();
    addr1 = 8'h21; req1 = 0;
    #1;
    n_checks++; if (mem_addr !== 8'h20) begin n_fail++; $display("FAIL chg_resp_addr: mem_addr=%h want 20", mem_addr); end
    for (int i = 0; i < 6; i++) begin
      if (ack1) pulses++;
      tick();
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL chg_ack_once: pulses=%0d want 1", pulses); end
    req0 = 1; we0 = 0; addr0 = 8'h20;
    tick(); tick(); tick();
    n_checks++; if (ack0 !== 1'b1 || rdata !== 8'h3E) begin n_fail++; $display("FAIL chg_read20: ack0=%b rdata=%h want 1 3e", ack0, rdata); end
    addr0 = 8'h21;
    tick();
    tick(); tick(); tick();
    n_checks++; if (ack0 !== 1'b1 || rdata !== 8'h00) begin n_fail++; $display("FAIL chg_read21: ack0=%b rdata=%h want 1 00", ack0, rdata); end
    req0 = 0;
    tick();
  endtask

  task automatic test_raw_cross();
    req1 = 1; we1 = 1; addr1 = 8'h80; wdata1 = 8'hFF;
    tick(); tick(); tick();
    n_checks++; if ({ack0, ack1} !== 2'b01) begin n_fail++; $display("FAIL raw_wr_ack: got %b want 01", {ack0, ack1}); end
    req1 = 0; we1 = 0;
    tick();
    req0 = 1; we0 = 0; addr0 = 8'h80;
    tick(); tick(); tick();
    n_checks++; if (ack0 !== 1'b1 || rdata !== 8'hFF) begin n_fail++; $display("FAIL raw_rd: ack0=%b rdata=%h want 1 ff", ack0, rdata); end
    req0 = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    req0 = 1; we0 = 1; addr0 = 8'h81; wdata0 = 8'h11;
    tick(); tick(); tick();
    n_checks++; if (ack0 !== 1'b1 || rdata !== 8'hFF) begin n_fail++; $display("FAIL b2b_wr_ack: ack0=%b rdata=%h want 1 ff", ack0, rdata); end
    we0 = 0;
    tick();
    n_checks++; if ({busy, ack0} !== 2'b00) begin n_fail++; $display("FAIL b2b_t4_idle: got %b want 00", {busy, ack0}); end
    tick();
    n_checks++; if ({mem_get, mem_addr} !== 9'h181) begin n_fail++; $display("FAIL b2b_rd_issue: got %h want 181", {mem_get, mem_addr}); end
    tick(); tick();
    n_checks++; if (ack0 !== 1'b1 || rdata !== 8'h11) begin n_fail++; $display("FAIL b2b_rd_ack: ack0=%b rdata=%h want 1 11", ack0, rdata); end
    req0 = 0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_single_port0();
    test_tie();
    test_contention();
    test_addr_change();
    test_raw_cross();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
